// File: rtl/gates_pipe.sv
// gates_pipe: runtime-selected 3-input bitwise logic function carried through a
// STAGES-deep valid-tagged pipeline with global stall and a saturating result count.
// Optional: define GATES_PIPE_PARITY_EN to add a registered z_parity output.
module gates_pipe #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             in_valid,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C,
    input  logic             clr_cnt,
`ifdef GATES_PIPE_PARITY_EN
    output logic             z_parity,
`endif
    output logic [WIDTH-1:0] Z,
    output logic             out_valid,
    output logic [CNT_W-1:0] result_cnt
);

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_XOR  = 3'd2;
    localparam logic [2:0] OP_NAND = 3'd3;
    localparam logic [2:0] OP_NOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;
    localparam logic [2:0] OP_MAJ  = 3'd6;

    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
        $error("gates_pipe: STAGES must be in 1..4");
    end

    logic [STAGES-1:0] r_vld;
    logic [WIDTH-1:0]  r_dat [STAGES];
    logic [CNT_W-1:0]  r_cnt;
    logic [WIDTH-1:0]  w_f;
    logic [STAGES:0]   w_chain;
    logic [WIDTH-1:0]  w_dchain [STAGES];

    // Stage-1 logic function
    always_comb begin
        w_f = '0;
        case (op)
            OP_AND:  w_f = A & B & C;
            OP_OR:   w_f = A | B | C;
            OP_XOR:  w_f = A ^ B ^ C;
            OP_NAND: w_f = ~(A & B & C);
            OP_NOR:  w_f = ~(A | B | C);
            OP_XNOR: w_f = ~(A ^ B ^ C);
            OP_MAJ:  w_f = (A & B) | (A & C) | (B & C);
            default: w_f = (C & B) | (~C & A);
        endcase
    end

    // Entry k of each chain is what feeds stage k (index 0 = the inputs)
    assign w_chain = {r_vld, in_valid};

    always_comb begin
        w_dchain[0] = w_f;
        for (int k = 1; k < STAGES; k++) begin
            w_dchain[k] = r_dat[k-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vld <= '0;
            for (int k = 0; k < STAGES; k++) begin
                r_dat[k] <= '0;
            end
        end else if (en) begin
            for (int k = 0; k < STAGES; k++) begin
                r_vld[k] <= w_chain[k];
                if (w_chain[k]) begin
                    r_dat[k] <= w_dchain[k];
                end
            end
        end
    end

    // Count each delivery once: only on edges that actually load the last stage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (clr_cnt) begin
            r_cnt <= '0;
        end else if (en && w_chain[STAGES-1] && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

`ifdef GATES_PIPE_PARITY_EN
    logic r_par;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_par <= 1'b0;
        end else if (en && w_chain[STAGES-1]) begin
            r_par <= ^w_dchain[STAGES-1];
        end
    end

    assign z_parity = r_par;
`endif

    assign Z          = r_dat[STAGES-1];
    assign out_valid  = r_vld[STAGES-1];
    assign result_cnt = r_cnt;

endmodule

// File: tb/tb_gates_pipe.sv
// Directed self-checking bench for gates_pipe: latency, op sweep, stall,
// bubbles, counter saturation/clear and asynchronous reset.
module tb_gates_pipe;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       in_valid;
    logic [2:0] op;
    logic [3:0] A, B, C;
    logic       clr_cnt;
    logic [3:0] Z, Z_s;
    logic       out_valid, out_valid_s;
    logic [7:0] result_cnt;
    logic [2:0] result_cnt_s;
`ifdef GATES_PIPE_PARITY_EN
    logic       z_parity, z_parity_s;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    gates_pipe #(.WIDTH(4), .STAGES(2), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .en(en), .in_valid(in_valid), .op(op),
        .A(A), .B(B), .C(C), .clr_cnt(clr_cnt),
`ifdef GATES_PIPE_PARITY_EN
        .z_parity(z_parity),
`endif
        .Z(Z), .out_valid(out_valid), .result_cnt(result_cnt)
    );

    // Narrow-counter instance sharing the same stimulus
    gates_pipe #(.WIDTH(4), .STAGES(2), .CNT_W(3)) dut_s (
        .clk(clk), .reset(reset), .en(en), .in_valid(in_valid), .op(op),
        .A(A), .B(B), .C(C), .clr_cnt(clr_cnt),
`ifdef GATES_PIPE_PARITY_EN
        .z_parity(z_parity_s),
`endif
        .Z(Z_s), .out_valid(out_valid_s), .result_cnt(result_cnt_s)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] o,
                         input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
        in_valid = v; op = o; A = a; B = b; C = c;
    endtask

    task automatic clear_counts();
        drive(1'b0, 3'd0, 4'h0, 4'h0, 4'h0);
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
    endtask

    logic [3:0] sweep_exp [8];

    initial begin
        sweep_exp = '{4'b0000, 4'b0111, 4'b0000, 4'b1111,
                      4'b1000, 4'b1111, 4'b0111, 4'b0101};
        reset = 1'b1; en = 1'b1; clr_cnt = 1'b0;
        drive(1'b0, 3'd0, 4'h0, 4'h0, 4'h0);
        #100;
        check("rst_z",   32'(Z), 32'h0);
        check("rst_ov",  32'(out_valid), 32'h0);
        check("rst_cnt", 32'(result_cnt), 32'h0);
        reset = 1'b0;

        // Reset/latency
        drive(1'b1, 3'd0, 4'b1100, 4'b1010, 4'b1111);
        tick();
        drive(1'b0, 3'd0, 4'h0, 4'h0, 4'h0);
        check("lat_ov_early", 32'(out_valid), 32'h0);
        tick();
        check("lat_z",   32'(Z), 32'h8);
        check("lat_ov",  32'(out_valid), 32'h1);
        check("lat_cnt", 32'(result_cnt), 32'h1);
        tick();
        check("lat_ov_drop", 32'(out_valid), 32'h0);
        check("lat_z_hold",  32'(Z), 32'h8);

        // Op sweep
        clear_counts();
        check("clr_cnt", 32'(result_cnt), 32'h0);
        for (int i = 0; i < 9; i++) begin
            if (i < 8) drive(1'b1, 3'(i), 4'b0011, 4'b0101, 4'b0110);
            else       drive(1'b0, 3'd0, 4'h0, 4'h0, 4'h0);
            tick();
            if (i >= 1) begin
                check($sformatf("sweep_z%0d", i-1), 32'(Z), 32'(sweep_exp[i-1]));
                check($sformatf("sweep_ov%0d", i-1), 32'(out_valid), 32'h1);
`ifdef GATES_PIPE_PARITY_EN
                check($sformatf("sweep_par%0d", i-1), 32'(z_parity), 32'(^sweep_exp[i-1]));
`endif
            end
        end
        check("sweep_cnt", 32'(result_cnt), 32'd8);

        // Stall: XOR with B=C=0 makes Z equal to A
        clear_counts();
        drive(1'b1, 3'd2, 4'd1, 4'd0, 4'd0);
        tick();
        drive(1'b1, 3'd2, 4'd2, 4'd0, 4'd0);
        tick();
        check("stall_pre_z", 32'(Z), 32'd1);
        en = 1'b0;
        drive(1'b1, 3'd2, 4'd9, 4'd0, 4'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("stall_z%0d", i),   32'(Z), 32'd1);
            check($sformatf("stall_ov%0d", i),  32'(out_valid), 32'h1);
            check($sformatf("stall_cnt%0d", i), 32'(result_cnt), 32'd1);
        end
        en = 1'b1;
        drive(1'b1, 3'd2, 4'd3, 4'd0, 4'd0);
        tick();
        check("resume_z2", 32'(Z), 32'd2);
        drive(1'b1, 3'd2, 4'd4, 4'd0, 4'd0);
        tick();
        check("resume_z3", 32'(Z), 32'd3);
        drive(1'b0, 3'd2, 4'd9, 4'd0, 4'd0);
        tick();
        check("resume_z4",  32'(Z), 32'd4);
        check("resume_cnt", 32'(result_cnt), 32'd4);
        tick();
        check("resume_ov_end", 32'(out_valid), 32'h0);

        // Bubbles
        drive(1'b1, 3'd2, 4'd5, 4'd0, 4'd0);
        tick();
        drive(1'b0, 3'd2, 4'd15, 4'd0, 4'd0);
        tick();
        check("bub_z5",   32'(Z), 32'd5);
        check("bub_ov1",  32'(out_valid), 32'h1);
        drive(1'b1, 3'd2, 4'd6, 4'd0, 4'd0);
        tick();
        check("bub_hold", 32'(Z), 32'd5);
        check("bub_ov0",  32'(out_valid), 32'h0);
        drive(1'b0, 3'd2, 4'd15, 4'd0, 4'd0);
        tick();
        check("bub_z6",   32'(Z), 32'd6);
        check("bub_ov1b", 32'(out_valid), 32'h1);

        // Counter saturation on the CNT_W=3 instance
        clear_counts();
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 3'd1, 4'(i), 4'd0, 4'd0);
            tick();
        end
        drive(1'b0, 3'd0, 4'd0, 4'd0, 4'd0);
        tick();
        check("sat_cnt_s", 32'(result_cnt_s), 32'd7);
        check("sat_cnt",   32'(result_cnt), 32'd9);
        check("sat_z_s",   32'(Z_s), 32'd8);
        drive(1'b1, 3'd1, 4'd3, 4'd0, 4'd0);
        tick();
        drive(1'b0, 3'd0, 4'd0, 4'd0, 4'd0);
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        check("clr_win_ov",  32'(out_valid), 32'h1);
        check("clr_win_cnt", 32'(result_cnt), 32'd0);
        check("clr_win_s",   32'(result_cnt_s), 32'd0);

        // Asynchronous reset with ops in flight
        drive(1'b1, 3'd2, 4'd7, 4'd0, 4'd0);
        tick();
        drive(1'b1, 3'd2, 4'd8, 4'd0, 4'd0);
        tick();
        check("pre_rst_z", 32'(Z), 32'd7);
        #2;
        reset = 1'b1;
        #1;
        check("arst_z",   32'(Z), 32'd0);
        check("arst_ov",  32'(out_valid), 32'h0);
        check("arst_cnt", 32'(result_cnt), 32'd0);
        drive(1'b0, 3'd0, 4'd0, 4'd0, 4'd0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("post_rst_ov%0d", i), 32'(out_valid), 32'h0);
            check($sformatf("post_rst_z%0d", i),  32'(Z), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
